// File: rtl/bool_sweep_eval_pkg.sv
// Shared types and helpers for the SoP/PoS truth-table sweeper.
package bool_sweep_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Index of the final input vector for an n-input function.
    function automatic int unsigned last_vec(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/sop_pos_eval.sv
// Structural evaluation of a function in SoP (minterm mask) and PoS (maxterm mask) form.
module sop_pos_eval #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]      vec,
    input  logic [(1<<N)-1:0] sop_q,
    input  logic [(1<<N)-1:0] pos_q,
    output logic              s_sop,
    output logic              s_pos
);

    localparam int unsigned W = 1 << N;

    // Minterm i is the AND of literals matching i; maxterm i is the OR of literals
    // that are 0 only at vector i.
    always_comb begin
        s_sop = 1'b0;
        s_pos = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            s_sop = s_sop | (sop_q[i] & (&(vec ~^ N'(i))));
            s_pos = s_pos & (~pos_q[i] | (|(vec ^ N'(i))));
        end
    end

endmodule

// File: rtl/bool_sweep_eval.sv
// Sweeps all 2^N input vectors, comparing the SoP and PoS forms of a function.
module bool_sweep_eval
    import bool_sweep_eval_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [(1<<N)-1:0] sop_mask,
    input  logic [(1<<N)-1:0] pos_mask,
    output logic [N-1:0]      vec,
    output logic              s_sop,
    output logic              s_pos,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [N:0]        mismatch_cnt,
    output logic [N-1:0]      first_bad,
    output logic              any_bad
);

    localparam int unsigned W    = 1 << N;
    localparam int unsigned CW   = N + 1;
    localparam logic [N-1:0] LAST = N'(last_vec(N));

    state_t          state, state_nx;
    logic [W-1:0]    sop_q, pos_q, sop_nx, pos_nx;
    logic [N-1:0]    vec_nx, first_bad_nx;
    logic [CW-1:0]   cnt_nx;
    logic            any_bad_nx, busy_nx, done_nx;
    logic            mis;

    sop_pos_eval #(.N(N)) u_eval (
        .vec   (vec),
        .sop_q (sop_q),
        .pos_q (pos_q),
        .s_sop (s_sop),
        .s_pos (s_pos)
    );

    assign mis = s_sop ^ s_pos;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sop_q        <= '0;
            pos_q        <= '0;
            vec          <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
            any_bad      <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            sop_q        <= sop_nx;
            pos_q        <= pos_nx;
            vec          <= vec_nx;
            mismatch_cnt <= cnt_nx;
            first_bad    <= first_bad_nx;
            any_bad      <= any_bad_nx;
            busy         <= busy_nx;
            valid        <= busy_nx;
            done         <= done_nx;
        end
    end

    // Next-state, counter and accumulator logic.
    always_comb begin
        state_nx     = state;
        sop_nx       = sop_q;
        pos_nx       = pos_q;
        vec_nx       = vec;
        cnt_nx       = mismatch_cnt;
        first_bad_nx = first_bad;
        any_bad_nx   = any_bad;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    sop_nx       = sop_mask;
                    pos_nx       = pos_mask;
                    vec_nx       = '0;
                    cnt_nx       = '0;
                    first_bad_nx = '0;
                    any_bad_nx   = 1'b0;
                    state_nx     = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (mis) begin
                    cnt_nx = mismatch_cnt + CW'(1);
                    if (!any_bad) begin
                        first_bad_nx = vec;
                        any_bad_nx   = 1'b1;
                    end
                end
                // Abort wins over the final-vector exit; vec never wraps past LAST.
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (vec == LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    vec_nx = vec + N'(1);
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        busy_nx = (state_nx == ST_SWEEP);
        done_nx = (state_nx == ST_DONE);
    end

endmodule

// File: tb/tb_bool_sweep_eval.sv
// Directed bench for bool_sweep_eval with N=2 and N=3 instances.
module tb_bool_sweep_eval;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start2, abort2, start3, abort3;
    logic [3:0] sop2, pos2;
    logic [7:0] sop3, pos3;
    logic [1:0] vec2, fb2;
    logic [2:0] vec3, fb3;
    logic [2:0] cnt2;
    logic [3:0] cnt3;
    logic       ssop2, spos2, valid2, busy2, done2, ab2;
    logic       ssop3, spos3, valid3, busy3, done3, ab3;

    int errors = 0;
    int checks = 0;

    bool_sweep_eval #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .sop_mask(sop2), .pos_mask(pos2), .vec(vec2), .s_sop(ssop2), .s_pos(spos2),
        .valid(valid2), .busy(busy2), .done(done2), .mismatch_cnt(cnt2),
        .first_bad(fb2), .any_bad(ab2)
    );

    bool_sweep_eval #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .sop_mask(sop3), .pos_mask(pos3), .vec(vec3), .s_sop(ssop3), .s_pos(spos3),
        .valid(valid3), .busy(busy3), .done(done3), .mismatch_cnt(cnt3),
        .first_bad(fb3), .any_bad(ab3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full sweep; esop/epos bit i is the expected output at vector i.
    task automatic sweep(input string name, input bit n3,
                         input logic [7:0] sm, input logic [7:0] pm,
                         input logic [7:0] esop, input logic [7:0] epos,
                         input logic [3:0] ecnt, input logic [2:0] efb, input logic eab);
        int steps;
        steps = n3 ? 8 : 4;
        @(negedge clk);
        if (n3) begin sop3 = sm; pos3 = pm; start3 = 1'b1; end
        else begin sop2 = sm[3:0]; pos2 = pm[3:0]; start2 = 1'b1; end
        @(negedge clk);
        start2 = 1'b0; start3 = 1'b0;
        // Masks are only sampled on the start edge.
        sop2 = ~sm[3:0]; pos2 = ~pm[3:0]; sop3 = ~sm; pos3 = ~pm;
        for (int i = 0; i < steps; i++) begin
            check($sformatf("%s valid v%0d", name, i), n3 ? 32'(valid3) : 32'(valid2), 1);
            check($sformatf("%s busy v%0d", name, i), n3 ? 32'(busy3) : 32'(busy2), 1);
            check($sformatf("%s vec v%0d", name, i), n3 ? 32'(vec3) : 32'(vec2), 32'(i));
            check($sformatf("%s s_sop v%0d", name, i), n3 ? 32'(ssop3) : 32'(ssop2), 32'(esop[i]));
            check($sformatf("%s s_pos v%0d", name, i), n3 ? 32'(spos3) : 32'(spos2), 32'(epos[i]));
            check($sformatf("%s done v%0d", name, i), n3 ? 32'(done3) : 32'(done2), 0);
            @(negedge clk);
        end
        check({name, " done pulse"}, n3 ? 32'(done3) : 32'(done2), 1);
        check({name, " valid in done"}, n3 ? 32'(valid3) : 32'(valid2), 0);
        check({name, " busy in done"}, n3 ? 32'(busy3) : 32'(busy2), 0);
        check({name, " mismatch_cnt"}, n3 ? 32'(cnt3) : 32'(cnt2), 32'(ecnt));
        check({name, " first_bad"}, n3 ? 32'(fb3) : 32'(fb2), 32'(efb));
        check({name, " any_bad"}, n3 ? 32'(ab3) : 32'(ab2), 32'(eab));
        @(negedge clk);
        check({name, " done one cycle"}, n3 ? 32'(done3) : 32'(done2), 0);
        check({name, " cnt held"}, n3 ? 32'(cnt3) : 32'(cnt2), 32'(ecnt));
        check({name, " first_bad held"}, n3 ? 32'(fb3) : 32'(fb2), 32'(efb));
    endtask

    initial begin
        rst_n = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; sop2 = '0; pos2 = '0;
        start3 = 1'b0; abort3 = 1'b0; sop3 = '0; pos3 = '0;
        #12;
        check("rst vec", 32'(vec2), 0);
        check("rst valid", 32'(valid2), 0);
        check("rst busy", 32'(busy2), 0);
        check("rst done", 32'(done2), 0);
        check("rst cnt", 32'(cnt2), 0);
        check("rst s_sop", 32'(ssop2), 0);
        check("rst s_pos", 32'(spos2), 1);
        @(negedge clk);
        rst_n = 1'b1;

        sweep("xor", 1'b0, 8'h06, 8'h09, 8'h06, 8'h06, 4'd0, 3'd0, 1'b0);
        sweep("xor_bad0", 1'b0, 8'h06, 8'h08, 8'h06, 8'h07, 4'd1, 3'd0, 1'b1);
        sweep("all_bad", 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h00, 4'd4, 3'd0, 1'b1);
        sweep("bad_at2", 1'b0, 8'h07, 8'h0C, 8'h07, 8'h03, 4'd1, 3'd2, 1'b1);
        sweep("majority", 1'b1, 8'hE8, 8'h17, 8'hE8, 8'hE8, 4'd0, 3'd0, 1'b0);

        // Extra start during the sweep is ignored, then abort before the end.
        @(negedge clk);
        sop2 = 4'b0110; pos2 = 4'b1000; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("abort c1 vec", 32'(vec2), 0);
        @(negedge clk);
        start2 = 1'b1;
        check("abort c2 vec", 32'(vec2), 1);
        @(negedge clk);
        start2 = 1'b0; abort2 = 1'b1;
        check("abort c3 vec", 32'(vec2), 2);
        check("abort c3 busy", 32'(busy2), 1);
        @(negedge clk);
        abort2 = 1'b0;
        check("abort c4 busy", 32'(busy2), 0);
        check("abort c4 valid", 32'(valid2), 0);
        check("abort c4 done", 32'(done2), 0);
        check("abort cnt held", 32'(cnt2), 1);
        check("abort first_bad", 32'(fb2), 0);
        check("abort any_bad", 32'(ab2), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort idle done c%0d", 5 + i), 32'(done2), 0);
            check($sformatf("abort idle busy c%0d", 5 + i), 32'(busy2), 0);
        end
        check("abort cnt still held", 32'(cnt2), 1);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        sop2 = 4'hF; pos2 = 4'hF; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        check("prerst cnt", 32'(cnt2), 1);
        check("prerst vec", 32'(vec2), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst vec", 32'(vec2), 0);
        check("midrst valid", 32'(valid2), 0);
        check("midrst busy", 32'(busy2), 0);
        check("midrst cnt", 32'(cnt2), 0);
        check("midrst any_bad", 32'(ab2), 0);
        check("midrst first_bad", 32'(fb2), 0);
        check("midrst s_sop", 32'(ssop2), 0);
        check("midrst s_pos", 32'(spos2), 1);
        @(negedge clk);
        check("midrst done", 32'(done2), 0);
        rst_n = 1'b1;
        sweep("post_rst", 1'b0, 8'h07, 8'h0C, 8'h07, 8'h03, 4'd1, 3'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
